// File: rtl/time_keeper_pkg.sv
// Shared time-of-day constants for the time keeper and its field counters.
package time_keeper_pkg;

  localparam int SEC_W    = 6;
  localparam int MIN_W    = 6;
  localparam int HR_W     = 5;

  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HR24_MAX = 23;
  localparam int HR12_MAX = 12;
  localparam int HR12_MIN = 1;

  // Hour at which the 12-hour clock flips between AM and PM on the next increment.
  localparam int HR12_PM_FLIP = 11;

endpackage

// File: rtl/time_keeper_mod_counter.sv
// Wrapping field counter: counts MIN..MAX, carry flags the MAX->MIN wrap.
// clr has priority over inc and loads MIN.
module mod_counter #(
  parameter int WIDTH     = 6,
  parameter int MIN       = 0,
  parameter int MAX       = 59,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             carry
);

  localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  assign carry = inc & ~clr & (count_q == MAX_V);
  assign count = count_q;

  // Next count: clear, wrap at MAX, or step by one.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = MIN_V;
    end else if (inc) begin
      count_d = (count_q == MAX_V) ? MIN_V : count_q + WIDTH'(1);
    end
  end

  // Count register with asynchronous clear to its reset value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count_q <= RST_V;
    else      count_q <= count_d;
  end

endmodule

// File: rtl/time_keeper.sv
// Time-of-day counter driven by the 1 Hz tick from the clock divider.
// The tick is synchronised, edge-detected and gated by an arming flag so a
// tick already high at reset release cannot produce a spurious advance.
import time_keeper_pkg::*;

module time_keeper #(
  parameter int TWELVE_HR   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_in,
  input  logic             set_en,
  input  logic             set_sel,
  input  logic             set_inc,
  output logic [HR_W-1:0]  hours,
  output logic [MIN_W-1:0] minutes,
  output logic [SEC_W-1:0] seconds,
  output logic             pm,
  output logic             sec_pulse,
  output logic             min_pulse,
  output logic             day_pulse
);

  localparam bit IS_12H   = (TWELVE_HR != 0);
  localparam int HR_MIN_P = IS_12H ? HR12_MIN : 0;
  localparam int HR_MAX_P = IS_12H ? HR12_MAX : HR24_MAX;
  localparam int HR_RST_P = IS_12H ? HR12_MAX : 0;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] vld_q;
  logic                   hist_q;
  logic                   armed_q;
  logic                   edge_q;
  logic                   set_q;
  logic                   pm_q, pm_d;
  logic                   sec_pulse_q, min_pulse_q, day_pulse_q;
  logic                   day_d;

  logic tick_lvl, set_rise, adv;
  logic sec_carry, min_carry, hr_carry;
  logic min_inc, hr_inc, at_pm_flip;

  assign tick_lvl = sync_q[SYNC_STAGES-1];

  // Synchroniser, history and arming. vld_q tracks how far real tick_in data
  // has filled the chain since reset, so the reset zeros in sync_q are not
  // mistaken for a low tick and cannot arm the edge detector.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= '0;
      vld_q   <= '0;
      hist_q  <= 1'b0;
      armed_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], tick_in};
      vld_q   <= {vld_q[SYNC_STAGES-2:0], 1'b1};
      hist_q  <= tick_lvl;
      armed_q <= armed_q | (vld_q[SYNC_STAGES-1] & ~tick_lvl);
      edge_q  <= armed_q & tick_lvl & ~hist_q;
    end
  end

  // Advance/set decode. Set mode swallows edges and its increments never carry.
  always_comb begin
    set_rise   = set_en & ~set_q;
    adv        = edge_q & ~set_en;
    min_inc    = (adv & sec_carry) | (set_en & set_inc & ~set_sel);
    hr_inc     = (adv & sec_carry & min_carry) | (set_en & set_inc & set_sel);
    at_pm_flip = (hours == HR_W'(HR12_PM_FLIP));
    pm_d       = pm_q;
    day_d      = 1'b0;
    if (IS_12H) begin
      if (hr_inc && at_pm_flip) pm_d = ~pm_q;
      day_d = adv & sec_carry & min_carry & at_pm_flip & pm_q;
    end else begin
      day_d = adv & sec_carry & min_carry & hr_carry;
    end
  end

  // Set-edge history, AM/PM flag and registered carry pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      set_q       <= 1'b0;
      pm_q        <= 1'b0;
      sec_pulse_q <= 1'b0;
      min_pulse_q <= 1'b0;
      day_pulse_q <= 1'b0;
    end else begin
      set_q       <= set_en;
      pm_q        <= pm_d;
      sec_pulse_q <= adv;
      min_pulse_q <= adv & sec_carry;
      day_pulse_q <= day_d;
    end
  end

  mod_counter #(.WIDTH(SEC_W), .MIN(0), .MAX(SEC_MAX), .RESET_VAL(0)) u_sec (
    .clk(clk), .rst(rst), .inc(adv), .clr(set_rise),
    .count(seconds), .carry(sec_carry)
  );

  mod_counter #(.WIDTH(MIN_W), .MIN(0), .MAX(MIN_MAX), .RESET_VAL(0)) u_min (
    .clk(clk), .rst(rst), .inc(min_inc), .clr(1'b0),
    .count(minutes), .carry(min_carry)
  );

  mod_counter #(.WIDTH(HR_W), .MIN(HR_MIN_P), .MAX(HR_MAX_P), .RESET_VAL(HR_RST_P)) u_hr (
    .clk(clk), .rst(rst), .inc(hr_inc), .clr(1'b0),
    .count(hours), .carry(hr_carry)
  );

  assign pm        = pm_q;
  assign sec_pulse = sec_pulse_q;
  assign min_pulse = min_pulse_q;
  assign day_pulse = day_pulse_q;

endmodule

// File: doc/time_keeper.md
Name: time_keeper

Overview:
- Consumer end of the 1 Hz timebase. Takes the divided square wave from the clock divider and samples it in the fast system clock domain.
- Detects its rising edges and advances a binary hours/minutes/seconds time-of-day counter.
- Supports a manual set mode for hours and minutes, and emits one-cycle carry pulses for downstream display and alarm logic.

Parameters:
- TWELVE_HR, 0: 0 = hours count 0..23; 1 = hours count 1..12 with an AM/PM flag.
- SYNC_STAGES, 2: number of synchroniser flops on tick_in. Legal values are 2 or 3.

Ports:
- clk  in  1  system clock (same clock that drives the divider).
- rst  in  1  asynchronous, active-low reset.
- tick_in  in  1  1 Hz square wave from the divider. Treated as asynchronous.
- set_en  in  1  1 = set mode: time frozen, set_inc is honoured.
- set_sel  in  1  field to adjust: 0 = minutes, 1 = hours.
- set_inc  in  1  single-cycle pulse; increments the selected field.
- hours  out  5  current hour, binary.
- minutes  out  6  current minute, 0..59.
- seconds  out  6  current second, 0..59.
- pm  out  1  PM flag. Meaningful only when TWELVE_HR=1; otherwise 0.
- sec_pulse  out  1  one-cycle pulse on every second advance.
- min_pulse  out  1  one-cycle pulse when seconds wrap 59->0.
- day_pulse  out  1  one-cycle pulse when the time wraps to the start of day.

Behaviour:
- Reset (rst=0, asynchronous, no clock required):
  - seconds=0, minutes=0, pm=0.
  - hours=0 when TWELVE_HR=0; hours=12 when TWELVE_HR=1.
  - All pulses = 0, synchroniser flops = 0, armed = 0.
- Synchroniser: tick_in passes through SYNC_STAGES flops, then one history flop. An edge is a synced level of 1 with history 0.
- Arming:
  - The armed flag sets on the first cycle the synced level is 0.
  - Edges are ignored while armed = 0, so a tick_in held high through reset release never causes an advance.
- Latency: with SYNC_STAGES=2, a tick_in rise sampled at edge N updates seconds/sec_pulse in the register outputs visible after edge N+3.
- Advance (edge detected and set_en=0):
  - seconds += 1.
  - 59 -> 0 increments minutes and raises min_pulse.
  - minutes 59 -> 0 increments hours.
- Hours, TWELVE_HR=0:
  - 23 -> 0 on carry; day_pulse on 23:59:59 -> 00:00:00.
- Hours, TWELVE_HR=1:
  - 12 -> 1 on carry.
  - 11 -> 12 toggles pm.
  - day_pulse on 11:59:59 pm -> 12:00:00 am.
- All pulses of one advance assert in the same cycle and last exactly one cycle.
- Set mode (set_en=1):
  - Edges are consumed but produce no advance and no pulses.
  - On the first cycle set_en is 1 (rising), seconds clear to 0.
  - set_inc increments only the selected field, with no carry into other fields.
  - Minutes wrap 59->0. Hours wrap 23->0 (24h) or 12->1 (12h). pm toggles on an hour set 11->12.
  - set_inc while set_en=0 is ignored.
- Simultaneous events:
  - set_en rising in the same cycle as an edge: set wins and the edge is dropped.
  - set_en falling: counting resumes on the next detected edge.
- Reset mid-operation: the asynchronous clear applies immediately. After release, armed must be re-established before any advance.
- Widths: all counters are compared against constants. No out-of-range values are ever reachable. All arithmetic is unsigned.

Decomposition:
- Shared package, time constants:
  - SEC_MAX=59, MIN_MAX=59.
  - HR24_MAX=23, HR12_MAX=12, HR12_MIN=1.
  - Field widths SEC_W=6, MIN_W=6, HR_W=5.
- Sub-module mod_counter: parameterised MIN/MAX/WIDTH/RESET_VAL; inputs inc and clr, output carry on MAX->MIN wrap. Instantiated three times (seconds, minutes, hours).
- Edge synchroniser and arming stay inline.

Test Plan:
- Hold tick_in=1 during and after rst release for 10 cycles, then drop it and raise it -> no advance until that rise; seconds=1 exactly 3 cycles after the rise.
- set_en=1, set_sel=1, 23 set_inc pulses; set_sel=0, 59 pulses; set_en=0; 59 ticks -> 23:59:59. Next tick -> 00:00:00 with sec_pulse, min_pulse and day_pulse high together for one cycle.
- Mid-count at 00:00:37, raise set_en -> seconds=0 next cycle. Ticks during set -> no change. set_inc with set_sel=1 at hours=23 -> hours=0, minutes unchanged, no pulses.
- Pull rst low asynchronously between clk edges at 05:12:40 -> all outputs 0 before the next clk edge. First tick after release produces no advance until tick_in has been seen low.
- TWELVE_HR=1: reset -> 12:00:00, pm=0. Set to 11:59, 59 ticks, then one tick -> 12:00:00, pm=1, no day_pulse. At 11:59:59 pm, tick -> 12:00:00, pm=0, day_pulse=1.
- set_inc asserted with set_en=0 coincident with a tick edge -> only the normal one-second advance occurs.
